// File: rtl/pcm_pkg.sv
// Shared definitions for the PCM record/playback path: FSM encodings and default sample pacing.
package pcm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_REC  = 2'd2,
    S_PLAY = 2'd3
  } pcm_state_t;

  // 50 MHz core clock / 16 kHz sample rate
  localparam int CLK_DIV_DEFAULT = 3125;

endpackage

// File: rtl/sample_tick_gen.sv
// Playback pacing: free-running divider, one-cycle tick every clk_div clocks while en is high.
// Counter is held at zero whenever en is low, so the first tick lands clk_div cycles after enable.
module sample_tick_gen #(
  parameter int clk_div = 3125
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(clk_div);
  localparam logic [CW-1:0] TERM = CW'(clk_div - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == TERM);

endmodule

// File: rtl/pcm_fifo_ctrl.sv
// Record/playback sequencer driving the cyclic sample FIFO; every output is registered (1-cycle latency).
// No backpressure: samples arriving while full set overrun and end the recording.
module pcm_fifo_ctrl
  import pcm_pkg::*;
#(
  parameter int dat_width = 16,
  parameter int adr_width = 12,
  parameter int clk_div   = CLK_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rec_start,
  input  logic                 play_start,
  input  logic                 stop,
  input  logic [dat_width-1:0] sample_in,
  input  logic                 sample_vld,
  output logic                 fifo_clr,
  output logic                 fifo_wr,
  output logic                 fifo_rd,
  output logic [dat_width-1:0] fifo_din,
  input  logic [dat_width-1:0] fifo_dout,
  input  logic                 fifo_empty,
  input  logic                 fifo_full,
  output logic [dat_width-1:0] pcm_out,
  output logic                 pcm_vld,
  output logic [adr_width:0]   n_samples,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam logic [adr_width:0] DEPTH = {1'b1, {adr_width{1'b0}}};
  localparam logic [adr_width:0] ONE   = (adr_width+1)'(1);

  pcm_state_t state;
  logic       tick;

  sample_tick_gen #(
    .clk_div (clk_div)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state == S_PLAY),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      fifo_clr  <= 1'b1;
      fifo_wr   <= 1'b0;
      fifo_rd   <= 1'b0;
      fifo_din  <= '0;
      pcm_out   <= '0;
      pcm_vld   <= 1'b0;
      n_samples <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      fifo_clr <= 1'b0;
      fifo_wr  <= 1'b0;
      fifo_rd  <= 1'b0;
      pcm_vld  <= 1'b0;
      done     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (rec_start) begin
            state     <= S_CLR;
            busy      <= 1'b1;
            fifo_clr  <= 1'b1;
            n_samples <= '0;
            overrun   <= 1'b0;
          end else if (play_start && (n_samples != '0)) begin
            state <= S_PLAY;
            busy  <= 1'b1;
          end
        end

        S_CLR: begin
          state <= stop ? S_IDLE : S_REC;
          busy  <= !stop;
        end

        S_REC: begin
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (n_samples == DEPTH) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (sample_vld) begin
            if (fifo_full) begin
              overrun <= 1'b1;
              state   <= S_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (!fifo_wr) begin
              // FIFO pointers move on the rd|wr edge, so back-to-back writes would merge
              fifo_din  <= sample_in;
              fifo_wr   <= 1'b1;
              n_samples <= n_samples + ONE;
            end
          end
        end

        S_PLAY: begin
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            if (!fifo_empty) begin
              pcm_out <= fifo_dout;
              pcm_vld <= 1'b1;
              fifo_rd <= 1'b1;
              if (n_samples != '0) n_samples <= n_samples - ONE;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_fifo_ctrl.sv
// Directed bench for pcm_fifo_ctrl with an 8-deep FWFT FIFO model and a 4-clock sample divider.
module tb_pcm_fifo_ctrl;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset, rec_start, play_start, stop, sample_vld;
  logic [DW-1:0] sample_in;
  logic          fifo_clr, fifo_wr, fifo_rd;
  logic [DW-1:0] fifo_din, fifo_dout;
  logic          fifo_empty, fifo_full;
  logic [DW-1:0] pcm_out;
  logic          pcm_vld;
  logic [AW:0]   n_samples;
  logic          busy, done, overrun;

  always #5 clk = ~clk;

  pcm_fifo_ctrl #(.dat_width(DW), .adr_width(AW), .clk_div(4)) dut (
    .clk(clk), .reset(reset), .rec_start(rec_start), .play_start(play_start), .stop(stop),
    .sample_in(sample_in), .sample_vld(sample_vld),
    .fifo_clr(fifo_clr), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_din(fifo_din),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .pcm_out(pcm_out), .pcm_vld(pcm_vld), .n_samples(n_samples),
    .busy(busy), .done(done), .overrun(overrun)
  );

  // FIFO model: first-word-fall-through, 8 entries, full can be overridden
  logic [DW-1:0] mem [8];
  logic [2:0]    wp, rp;
  logic [3:0]    cnt;
  logic          force_full;

  always @(posedge clk) begin
    if (fifo_clr) begin
      wp <= '0; rp <= '0; cnt <= '0;
    end else begin
      if (fifo_wr && cnt != 4'd8) begin
        mem[wp] <= fifo_din;
        wp      <= wp + 3'd1;
      end
      if (fifo_rd && cnt != 4'd0) rp <= rp + 3'd1;
      cnt <= cnt + ((fifo_wr && cnt != 4'd8) ? 4'd1 : 4'd0) - ((fifo_rd && cnt != 4'd0) ? 4'd1 : 4'd0);
    end
  end

  assign fifo_dout  = mem[rp];
  assign fifo_empty = (cnt == 4'd0);
  assign fifo_full  = (cnt == 4'd8) || force_full;

  // Cycle counter and event monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            wr_n = 0, rd_n = 0, clr_n = 0, done_n = 0;
  int            last_wr_cyc = 0, last_done_cyc = 0;
  int            vld_cyc [$];
  logic [DW-1:0] vld_dat [$];
  logic          prev_wr = 1'b0, prev_rd = 1'b0, proto_bad = 1'b0;

  always @(negedge clk) begin
    if (fifo_wr) begin wr_n <= wr_n + 1; last_wr_cyc <= cyc; end
    if (fifo_rd) rd_n <= rd_n + 1;
    if (fifo_clr) clr_n <= clr_n + 1;
    if (done) begin done_n <= done_n + 1; last_done_cyc <= cyc; end
    if (pcm_vld) begin vld_cyc.push_back(cyc); vld_dat.push_back(pcm_out); end
    if ((fifo_wr && fifo_rd) || (fifo_wr && prev_wr) || (fifo_rd && prev_rd)) proto_bad <= 1'b1;
    prev_wr <= fifo_wr;
    prev_rd <= fifo_rd;
  end

  int nvec = 0, nmis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // After return the DUT sits in REC (CLR consumed)
  task automatic start_rec();
    rec_start = 1'b1;
    cycles(1);
    rec_start = 1'b0;
    cycles(1);
  endtask

  task automatic send(input logic [DW-1:0] d, input int gap);
    sample_in  = d;
    sample_vld = 1'b1;
    cycles(1);
    sample_vld = 1'b0;
    cycles(gap - 1);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    cycles(1);
  endtask

  int s_wr, s_rd, s_clr, s_done, s_v, c0, k;
  logic [DW-1:0] exp_dat [3];

  initial begin
    reset = 1'b1; rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;
    sample_vld = 1'b0; sample_in = '0; force_full = 1'b0;
    exp_dat[0] = 16'h0011; exp_dat[1] = 16'h0022; exp_dat[2] = 16'h0033;
    cycles(3);
    chk("rst_clr", fifo_clr, 1);
    chk("rst_busy", busy, 0);
    chk("rst_n", n_samples, 0);
    chk("rst_vld", pcm_vld, 0);
    reset = 1'b0;
    cycles(2);
    chk("idle_clr", fifo_clr, 0);

    // Record three samples, then stop
    s_wr = wr_n; s_clr = clr_n; s_done = done_n;
    start_rec();
    send(16'h0011, 3); send(16'h0022, 3); send(16'h0033, 3);
    pulse_stop();
    cycles(2);
    chk("recA_clr", clr_n - s_clr, 1);
    chk("recA_wr", wr_n - s_wr, 3);
    chk("recA_n", n_samples, 3);
    chk("recA_done", done_n - s_done, 0);
    chk("recA_busy", busy, 0);

    // Playback of those three samples
    s_rd = rd_n; s_done = done_n; s_v = vld_cyc.size();
    c0 = cyc;
    play_start = 1'b1;
    cycles(1);
    play_start = 1'b0;
    k = 0;
    while (done_n == s_done && k < 40) begin cycles(1); k++; end
    chk("play_to", (done_n != s_done), 1);
    cycles(1);
    chk("play_cnt", vld_cyc.size() - s_v, 3);
    if (vld_cyc.size() - s_v == 3) begin
      chk("play_t0", vld_cyc[s_v] - c0, 5);
      for (int i = 0; i < 3; i++) chk($sformatf("play_d%0d", i), vld_dat[s_v+i], exp_dat[i]);
      chk("play_t1", vld_cyc[s_v+1] - vld_cyc[s_v], 4);
      chk("play_t2", vld_cyc[s_v+2] - vld_cyc[s_v+1], 4);
      chk("play_tdone", last_done_cyc - vld_cyc[s_v+2], 4);
    end
    chk("play_rd", rd_n - s_rd, 3);
    chk("play_n", n_samples, 0);
    chk("play_hold", pcm_out, 16'h0033);
    chk("play_busy", busy, 0);

    // Fill to depth: nine samples, ninth dropped
    s_wr = wr_n; s_done = done_n;
    start_rec();
    for (int i = 0; i < 9; i++) send(16'h0100 + 16'(i), 2);
    cycles(3);
    chk("fill_wr", wr_n - s_wr, 8);
    chk("fill_done", done_n - s_done, 1);
    chk("fill_done_t", last_done_cyc - last_wr_cyc, 1);
    chk("fill_n", n_samples, 8);
    chk("fill_ovr", overrun, 0);
    chk("fill_busy", busy, 0);

    // Forced full: overrun ends recording; CLR zeroes the count
    s_wr = wr_n; s_done = done_n;
    start_rec();
    chk("clr_n0", n_samples, 0);
    force_full = 1'b1;
    send(16'hBEEF, 2);
    cycles(1);
    force_full = 1'b0;
    chk("ovr_wr", wr_n - s_wr, 0);
    chk("ovr_flag", overrun, 1);
    chk("ovr_done", done_n - s_done, 1);
    chk("ovr_busy", busy, 0);
    rec_start = 1'b1;
    cycles(1);
    rec_start = 1'b0;
    chk("ovr_clear", overrun, 0);
    cycles(1);
    pulse_stop();

    // play_start with empty store is ignored
    s_done = done_n; s_v = vld_cyc.size();
    play_start = 1'b1;
    cycles(1);
    play_start = 1'b0;
    cycles(8);
    chk("play0_busy", busy, 0);
    chk("play0_done", done_n - s_done, 0);
    chk("play0_vld", vld_cyc.size() - s_v, 0);

    // Simultaneous starts: record wins
    s_wr = wr_n;
    rec_start = 1'b1; play_start = 1'b1;
    cycles(1);
    rec_start = 1'b0; play_start = 1'b0;
    chk("both_clr", fifo_clr, 1);
    cycles(1);
    send(16'h0AAA, 2); send(16'h0BBB, 2);
    pulse_stop();
    chk("both_wr", wr_n - s_wr, 2);
    chk("both_n", n_samples, 2);

    // Reset in the middle of playback
    play_start = 1'b1;
    cycles(1);
    play_start = 1'b0;
    k = 0;
    while (!pcm_vld && k < 20) begin cycles(1); k++; end
    chk("mid_vld_to", pcm_vld, 1);
    reset = 1'b1;
    cycles(1);
    chk("mid_busy", busy, 0);
    chk("mid_vld", pcm_vld, 0);
    chk("mid_rd", fifo_rd, 0);
    chk("mid_clr", fifo_clr, 1);
    chk("mid_n", n_samples, 0);
    reset = 1'b0;
    cycles(2);

    chk("proto", proto_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
